// File: rtl/shift_reg_pkg.sv
// Shared encodings for the shift-register sequencer: operations, FSM states,
// direction constants and the latched command payload.
package shift_reg_pkg;

  localparam int unsigned DATA_W = 4;
  localparam int unsigned OP_W   = 2;

  typedef enum logic [OP_W-1:0] {
    OP_SHIFT  = 2'b00,
    OP_ROTATE = 2'b01,
    OP_LOAD   = 2'b10,
    OP_HOLD   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CHECK = 2'd2
  } state_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef struct packed {
    op_e               op;
    logic              dir;
    logic [DATA_W-1:0] d;
    logic              sin;
  } cmd_t;

endpackage

// File: rtl/shift_reg_model.sv
// Next-value function of the controlled 4-bit shift register, used to track
// the expected register contents.
module shift_reg_model
  import shift_reg_pkg::*;
(
  input  logic [DATA_W-1:0] exp_i,
  input  cmd_t              cmd_i,
  output logic [DATA_W-1:0] exp_nxt_c
);

  always_comb begin
    exp_nxt_c = exp_i;
    case (cmd_i.op)
      OP_SHIFT:  exp_nxt_c = (cmd_i.dir == DIR_RIGHT) ? {cmd_i.sin, exp_i[DATA_W-1:1]}
                                                      : {exp_i[DATA_W-2:0], cmd_i.sin};
      OP_ROTATE: exp_nxt_c = (cmd_i.dir == DIR_LEFT)  ? {exp_i[DATA_W-2:0], exp_i[DATA_W-1]}
                                                      : {exp_i[0], exp_i[DATA_W-1:1]};
      OP_LOAD:   exp_nxt_c = cmd_i.d;
      default:   exp_nxt_c = exp_i;
    endcase
  end

endmodule

// File: rtl/shift_reg_sequencer.sv
// Command sequencer driving a 4-bit shift register for N cycles per command.
// Optional result checking against an internal model: SHIFT_REG_SEQ_COMPARE_EN.
module shift_reg_sequencer
  import shift_reg_pkg::*;
#(
  parameter int unsigned CNT_W = 3
) (
  input  logic              CLK,
  input  logic              RESET_L,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic [OP_W-1:0]   CMD_OP,
  input  logic              CMD_DIR,
  input  logic [DATA_W-1:0] CMD_D,
  input  logic              CMD_SIN,
  input  logic [CNT_W-1:0]  CMD_COUNT,
  output logic              ENB,
  output logic              DIR,
  output logic [OP_W-1:0]   MODO,
  output logic [DATA_W-1:0] D,
  output logic              S_IN,
  input  logic [DATA_W-1:0] Q_IN,
  output logic              DONE,
  output logic              ERR,
  output logic [3:0]        ERR_CNT
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  cmd_t             cmd_q, cmd_d;
  logic             enb_q, enb_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cmd_q   <= '{op: OP_SHIFT, dir: DIR_LEFT, d: '0, sin: 1'b0};
      enb_q   <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      enb_q   <= enb_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  // Outputs are computed from the next state so they line up with it after the edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    case (state_q)
      ST_IDLE: begin
        if (CMD_VALID && ready_q) begin
          cmd_d   = '{op: op_e'(CMD_OP), dir: CMD_DIR, d: CMD_D, sin: CMD_SIN};
          cnt_d   = (op_e'(CMD_OP) == OP_LOAD) ? CNT_W'(1) : CMD_COUNT;
          state_d = (cnt_d == '0) ? ST_CHECK : ST_RUN;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_CHECK;
      end
      ST_CHECK: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    enb_d   = (state_d == ST_RUN) && (cmd_d.op != OP_HOLD);
    done_d  = (state_d == ST_CHECK);
    ready_d = (state_d == ST_IDLE);
  end

  assign CMD_READY = ready_q;
  assign ENB       = enb_q;
  assign DIR       = cmd_q.dir;
  assign MODO      = cmd_q.op;
  assign D         = cmd_q.d;
  assign S_IN      = cmd_q.sin;
  assign DONE      = done_q;

`ifdef SHIFT_REG_SEQ_COMPARE_EN
  logic [DATA_W-1:0] exp_q, exp_d, exp_nxt_c;
  logic              err_q, err_d;
  logic [3:0]        err_cnt_q, err_cnt_d;

  shift_reg_model u_model (
    .exp_i     (exp_q),
    .cmd_i     (cmd_q),
    .exp_nxt_c (exp_nxt_c)
  );

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      exp_q     <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      exp_q     <= exp_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // EXP advances on the same edges the register sees ENB; compare happens in CHECK.
  always_comb begin
    exp_d     = exp_q;
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    if (enb_q) exp_d = exp_nxt_c;
    if ((state_q == ST_CHECK) && (Q_IN != exp_q)) begin
      err_d = 1'b1;
      if (err_cnt_q != 4'hF) err_cnt_d = err_cnt_q + 4'd1;
    end
  end

  assign ERR     = err_q;
  assign ERR_CNT = err_cnt_q;
`else
  logic unused_q_in;
  assign unused_q_in = ^Q_IN;
  assign ERR     = 1'b0;
  assign ERR_CNT = 4'd0;
`endif

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Directed self-checking bench for shift_reg_sequencer with a behavioural
// 4-bit shift register closing the Q loop.
module tb_shift_reg_sequencer;

`ifdef SHIFT_REG_SEQ_COMPARE_EN
  localparam bit CMP = 1'b1;
`else
  localparam bit CMP = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RESET_L;
  logic       CMD_VALID;
  logic       CMD_READY;
  logic [1:0] CMD_OP;
  logic       CMD_DIR;
  logic [3:0] CMD_D;
  logic       CMD_SIN;
  logic [2:0] CMD_COUNT;
  logic       ENB, DIR, S_IN, DONE, ERR;
  logic [1:0] MODO;
  logic [3:0] D, Q_IN, ERR_CNT;

  logic [3:0] q_reg;
  logic       force_zero = 1'b0;
  int         n_pass = 0;
  int         n_total = 0;

  always #5 CLK = ~CLK;

  shift_reg_sequencer #(.CNT_W(3)) dut (
    .CLK(CLK), .RESET_L(RESET_L), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_OP(CMD_OP), .CMD_DIR(CMD_DIR), .CMD_D(CMD_D), .CMD_SIN(CMD_SIN),
    .CMD_COUNT(CMD_COUNT), .ENB(ENB), .DIR(DIR), .MODO(MODO), .D(D), .S_IN(S_IN),
    .Q_IN(Q_IN), .DONE(DONE), .ERR(ERR), .ERR_CNT(ERR_CNT)
  );

  // Controlled register sharing RESET_L with the sequencer
  always @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) q_reg <= 4'b0000;
    else if (ENB) begin
      case (MODO)
        2'b00:   q_reg <= DIR ? {S_IN, q_reg[3:1]} : {q_reg[2:0], S_IN};
        2'b01:   q_reg <= DIR ? {q_reg[0], q_reg[3:1]} : {q_reg[2:0], q_reg[3]};
        2'b10:   q_reg <= D;
        default: q_reg <= q_reg;
      endcase
    end
  end

  assign Q_IN = force_zero ? 4'b0000 : q_reg;

  task automatic send(input logic [1:0] op, input logic dir, input logic [3:0] d,
                      input logic sin, input logic [2:0] cnt,
                      output logic [31:0] enb_mask, output int done_at,
                      output int ready_at, output bit ctl_ok);
    @(negedge CLK);
    CMD_VALID = 1'b1; CMD_OP = op; CMD_DIR = dir; CMD_D = d; CMD_SIN = sin; CMD_COUNT = cnt;
    enb_mask = '0; done_at = -1; ready_at = -1; ctl_ok = 1'b1;
    @(posedge CLK);
    for (int j = 1; j <= 20 && ready_at < 0; j++) begin
      @(negedge CLK);
      if (ENB) begin
        enb_mask[j] = 1'b1;
        if (MODO !== op || DIR !== dir || D !== d || S_IN !== sin) ctl_ok = 1'b0;
      end
      if (DONE) begin
        if (done_at < 0) done_at = j;
        else ctl_ok = 1'b0;
      end
      if (CMD_READY) begin
        ready_at = j;
        CMD_VALID = 1'b0;
      end else begin
        // busy: keep VALID up with junk that must be ignored
        CMD_OP = 2'($urandom); CMD_DIR = 1'($urandom); CMD_D = 4'($urandom);
        CMD_SIN = 1'($urandom); CMD_COUNT = 3'($urandom);
      end
    end
    CMD_VALID = 1'b0;
  endtask

  task automatic test_reset();
    RESET_L = 1'b0; CMD_VALID = 1'b0; CMD_OP = '0; CMD_DIR = 1'b0;
    CMD_D = '0; CMD_SIN = 1'b0; CMD_COUNT = '0;
    #12;
    n_total++;
    if ({ENB, DIR, MODO, D, S_IN, DONE} !== 10'b0)
      $display("FAIL reset_outs: got %b want %b", {ENB, DIR, MODO, D, S_IN, DONE}, 10'b0);
    else n_pass++;
    n_total++;
    if ({ERR, ERR_CNT} !== 5'b0) $display("FAIL reset_err: got %b want %b", {ERR, ERR_CNT}, 5'b0);
    else n_pass++;
    @(negedge CLK); RESET_L = 1'b1;
    @(negedge CLK);
    n_total++;
    if (CMD_READY !== 1'b1) $display("FAIL reset_ready: got %b want 1", CMD_READY);
    else n_pass++;
  endtask

  task automatic test_load();
    logic [31:0] m; int dn, rd; bit ok;
    send(2'b10, 1'b0, 4'b1011, 1'b0, 3'd5, m, dn, rd, ok);
    n_total++;
    if (m !== 32'h2) $display("FAIL load_enb: got %h want %h", m, 32'h2); else n_pass++;
    n_total++;
    if (dn !== 2 || rd !== 3) $display("FAIL load_timing: got done %0d ready %0d want 2 3", dn, rd);
    else n_pass++;
    n_total++;
    if (q_reg !== 4'b1011 || ERR !== 1'b0 || !ok)
      $display("FAIL load_q: got q %b err %b ctl %0d want 1011 0 1", q_reg, ERR, ok);
    else n_pass++;
  endtask

  task automatic test_shift_left();
    logic [31:0] m; int dn, rd; bit ok;
    send(2'b10, 1'b0, 4'b0000, 1'b0, 3'd1, m, dn, rd, ok);
    send(2'b00, 1'b0, 4'b0000, 1'b1, 3'd3, m, dn, rd, ok);
    n_total++;
    if (m !== 32'hE) $display("FAIL shl_enb: got %h want %h", m, 32'hE); else n_pass++;
    n_total++;
    if (dn !== 4 || rd !== 5) $display("FAIL shl_timing: got done %0d ready %0d want 4 5", dn, rd);
    else n_pass++;
    n_total++;
    if (q_reg !== 4'b0111 || ERR !== 1'b0 || !ok)
      $display("FAIL shl_q: got q %b err %b ctl %0d want 0111 0 1", q_reg, ERR, ok);
    else n_pass++;
  endtask

  task automatic test_rotate_right();
    logic [31:0] m; int dn, rd; bit ok;
    send(2'b10, 1'b0, 4'b1000, 1'b0, 3'd0, m, dn, rd, ok);
    send(2'b01, 1'b1, 4'b0000, 1'b0, 3'd4, m, dn, rd, ok);
    n_total++;
    if (m !== 32'h1E) $display("FAIL ror_enb: got %h want %h", m, 32'h1E); else n_pass++;
    n_total++;
    if (dn !== 5 || rd !== 6) $display("FAIL ror_timing: got done %0d ready %0d want 5 6", dn, rd);
    else n_pass++;
    n_total++;
    if (q_reg !== 4'b1000 || ERR !== 1'b0 || !ok)
      $display("FAIL ror_q: got q %b err %b ctl %0d want 1000 0 1", q_reg, ERR, ok);
    else n_pass++;
  endtask

  task automatic test_count_zero();
    logic [31:0] m; int dn, rd; bit ok;
    send(2'b00, 1'b0, 4'b0000, 1'b1, 3'd0, m, dn, rd, ok);
    n_total++;
    if (m !== 32'h0) $display("FAIL cnt0_enb: got %h want 0", m); else n_pass++;
    n_total++;
    if (dn !== 1 || rd !== 2) $display("FAIL cnt0_timing: got done %0d ready %0d want 1 2", dn, rd);
    else n_pass++;
    n_total++;
    if (q_reg !== 4'b1000 || !ok) $display("FAIL cnt0_q: got q %b ctl %0d want 1000 1", q_reg, ok);
    else n_pass++;
  endtask

  task automatic test_mismatch();
    logic [31:0] m; int dn, rd; bit ok;
    force_zero = 1'b1;
    send(2'b10, 1'b0, 4'b0101, 1'b0, 3'd1, m, dn, rd, ok);
    n_total++;
    if (ERR !== CMP || ERR_CNT !== (CMP ? 4'd1 : 4'd0))
      $display("FAIL mis_first: got err %b cnt %0d want %b %0d", ERR, ERR_CNT, CMP, CMP ? 1 : 0);
    else n_pass++;
    for (int i = 0; i < 16; i++) begin
      send(2'b11, 1'b0, 4'b0000, 1'b0, 3'd0, m, dn, rd, ok);
      if (i == 13) begin
        n_total++;
        if (ERR_CNT !== (CMP ? 4'd15 : 4'd0))
          $display("FAIL mis_reach15: got %0d want %0d", ERR_CNT, CMP ? 15 : 0);
        else n_pass++;
      end
    end
    n_total++;
    if (ERR !== CMP || ERR_CNT !== (CMP ? 4'd15 : 4'd0))
      $display("FAIL mis_sat: got err %b cnt %0d want %b %0d", ERR, ERR_CNT, CMP, CMP ? 15 : 0);
    else n_pass++;
    force_zero = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    bit seen;
    @(negedge CLK);
    CMD_VALID = 1'b1; CMD_OP = 2'b00; CMD_DIR = 1'b0; CMD_D = 4'b0000; CMD_SIN = 1'b1; CMD_COUNT = 3'd6;
    @(posedge CLK);
    @(negedge CLK); CMD_VALID = 1'b0;
    n_total++;
    if (ENB !== 1'b1) $display("FAIL rst_run_enb: got %b want 1", ENB); else n_pass++;
    @(posedge CLK); #2;
    RESET_L = 1'b0; #1;
    n_total++;
    if (ENB !== 1'b0 || DONE !== 1'b0 || CMD_READY !== 1'b1)
      $display("FAIL rst_mid: got enb %b done %b ready %b want 0 0 1", ENB, DONE, CMD_READY);
    else n_pass++;
    n_total++;
    if (ERR_CNT !== 4'd0 || ERR !== 1'b0 || q_reg !== 4'b0000)
      $display("FAIL rst_mid_state: got cnt %0d err %b q %b want 0 0 0000", ERR_CNT, ERR, q_reg);
    else n_pass++;
    @(negedge CLK); RESET_L = 1'b1;
    seen = 1'b0;
    for (int j = 0; j < 10; j++) begin
      @(negedge CLK);
      if (ENB || DONE || !CMD_READY) seen = 1'b1;
    end
    n_total++;
    if (seen !== 1'b0) $display("FAIL rst_idle_quiet: got activity %b want 0", seen); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_load();
    test_shift_left();
    test_rotate_right();
    test_count_zero();
    test_mismatch();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/shift_reg_sequencer.md
SHIFT_REG_SEQUENCER -- requirements
Module: shift_reg_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 3, width of the command cycle count.
REQ-002 SHALL have port CLK  input  1  the single clock; all state updates on the rising edge.
REQ-003 SHALL have port RESET_L  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port CMD_VALID  input  1  command present.
REQ-005 SHALL have port CMD_READY  output  1  sequencer able to accept a command.
REQ-006 SHALL have port CMD_OP  input  2  00 shift, 01 rotate, 10 parallel load, 11 hold.
REQ-007 SHALL have port CMD_DIR  input  1  0 left (toward bit 3), 1 right.
REQ-008 SHALL have port CMD_D  input  4  parallel load data.
REQ-009 SHALL have port CMD_SIN  input  1  serial input bit for shift operations.
REQ-010 SHALL have port CMD_COUNT  input  CNT_W  number of active clock cycles.
REQ-011 SHALL have ports ENB, DIR, MODO[1:0], D[3:0], S_IN  output  enable, direction, mode, load data and serial input driven to the 4-bit shift register.
REQ-012 SHALL have port Q_IN  input  4  Q returned by the controlled shift register.
REQ-013 SHALL have port DONE  output  1  one-cycle command-completion pulse.
REQ-014 SHALL have ports ERR (output 1, sticky mismatch flag) and ERR_CNT (output 4, mismatch count).

Function
REQ-015 SHALL implement FSM states IDLE, RUN, CHECK; all outputs registered.
REQ-016 SHALL assert CMD_READY only in IDLE; a command is accepted on a rising edge with CMD_VALID=1 and CMD_READY=1.
REQ-017 SHALL, on acceptance, latch OP/DIR/D/SIN, load the down-counter with CMD_COUNT (forced to 1 for load), and enter RUN, or CHECK directly if the count is 0.
REQ-018 SHALL, in RUN, drive MODO=CMD_OP, DIR, D, S_IN from latched values and ENB=1 (ENB=0 for hold); decrement the counter each cycle; enter CHECK after the cycle in which the counter equals 1.
REQ-019 SHALL keep an internal expected value EXP[3:0], updated every RUN cycle with ENB=1: shift left {EXP[2:0],SIN}; shift right {SIN,EXP[3:1]}; rotate left {EXP[2:0],EXP[3]}; rotate right {EXP[0],EXP[3:1]}; load D.
REQ-020 SHALL, in CHECK, drive ENB=0, pulse DONE for exactly one cycle, compare Q_IN with EXP, and return to IDLE on the next edge.
REQ-021 SHALL, on CHECK mismatch, set ERR and increment ERR_CNT, saturating at 15.
REQ-022 SHALL give latency: accept at edge k -> ENB high for cycles k+1..k+N -> DONE at k+N+1 -> CMD_READY at k+N+2.
REQ-023 SHALL ignore CMD_VALID and all CMD_* inputs outside IDLE.
REQ-024 SHALL ensure no ENB or DONE is produced while idle.

Reset
REQ-025 SHALL, with RESET_L=0 at any time including mid-RUN, go immediately to IDLE and hold ENB=0, DIR=0, MODO=00, D=0000, S_IN=0, DONE=0, EXP=0000, ERR=0, ERR_CNT=0, with CMD_READY=1 after release.
REQ-026 SHALL share RESET_L with the controlled register, which resets Q to 0000.

Configuration
REQ-027 SHALL, with SHIFT_REG_SEQ_COMPARE_EN defined, include EXP tracking and the CHECK comparison; without it, tie ERR=0 and ERR_CNT=0, omit EXP logic, and leave sequencing and timing unchanged.

Structure
REQ-028 SHALL place the CMD_OP/MODO encodings, FSM state typedef and direction constants in package shift_reg_pkg.
REQ-029 SHALL isolate the EXP next-value function in sub-module shift_reg_model, instantiated only under SHIFT_REG_SEQ_COMPARE_EN.

Verification
REQ-030 SHALL test load D=1011, count 5 -> one ENB cycle (count forced to 1), DONE one cycle later, Q=1011, ERR=0.
REQ-031 SHALL test shift left, SIN=1, count 3 from 0000 -> ENB high 3 cycles, Q=0111, DONE at k+4.
REQ-032 SHALL test rotate right from 1000, count 4 -> Q=1000 and EXP=1000; CMD_READY low throughout.
REQ-033 SHALL test count 0 -> no ENB, DONE at k+1, Q unchanged.
REQ-034 SHALL test a register model with Q_IN forced to 0000 after loading 0101 -> ERR=1, ERR_CNT=1; 16 further mismatches -> ERR_CNT=15.
REQ-035 SHALL test RESET_L low in the second RUN cycle of a count-6 shift -> ENB=0 immediately, IDLE, ERR_CNT=0, no DONE.
